ps2_keyboard: RTL and testbench
===============================

// Module: ps2_keyboard
// PURPOSE
//   PS/2 keyboard receiver on the 6502 bus, selected by ps2_cs (0xC200-0xC2FF).
//   Filters the PS/2 clock and data lines, deserialises 11-bit device-to-host frames and
//   checks them. Queues valid scancodes in a FIFO for the CPU to read.
//   Raises an optional level interrupt while data is pending.
// PARAMETERS
//   FILTER_LEN      8      cycles a synchronised ps2_clk level must hold before it is accepted
//   TIMEOUT_CYCLES  25000  max clk cycles between falling edges within a frame (1 ms @ 25 MHz)
//   FIFO_DEPTH      16     scancode FIFO entries; must be a power of 2, >=2
// PORTS
//   clk        in   1  system clock
//   rst_n      in   1  asynchronous active-low reset
//   ps2_cs     in   1  chip select from address_decoder
//   bus_ce     in   1  one-cycle strobe marking the cycle a CPU access completes
//   we         in   1  1 = CPU write, 0 = CPU read
//   addr       in   2  register offset, addr[1:0]
//   data_in    in   8  CPU write data
//   data_out   out  8  read data; combinational from addr and state
//   irq        out  1  irq_en & ~fifo_empty
//   ps2_clk    in   1  raw PS/2 clock pin, asynchronous
//   ps2_data   in   1  raw PS/2 data pin, asynchronous
// BEHAVIOUR
//   Registers, decoded by addr[1:0]; upper address bits are ignored, so registers alias across the page:
//   - 0 DATA, read-only
//     - Returns the FIFO head, or 0x00 when the FIFO is empty.
//     - The FIFO pops when ps2_cs & bus_ce & ~we.
//   - 1 STATUS
//     - Read bits: [0] not_empty, [1] full, [2] overrun, [3] parity_err, [4] frame_err, [7] irq_en, others 0.
//     - Write with ps2_cs & bus_ce & we: bits 2-4 are write-1-to-clear; bit 7 loads irq_en; other bits are ignored.
//   - 2, 3: read 0x00; writes are ignored.
//   Reset: FIFO empty, all sticky flags 0, irq_en 0, receiver in IDLE.
//     - Outputs at reset: irq=0, data_out=0x00 for DATA and STATUS reads.
//   Input path: 2-FF synchroniser on each pin.
//     - ps2_clk then passes a stability filter: the filtered level changes only after FILTER_LEN consecutive equal samples.
//     - Falling edge of the filtered clock = fe, a 1-cycle pulse.
//     - ps2_data is sampled (synchronised) on the fe cycle.
//   Receiver FSM, advancing only on fe:
//     - IDLE: bit=0 (start) -> DATA with bit count=0; bit=1 -> stay in IDLE, no error.
//     - DATA: shift LSB first; after the 8th bit -> PARITY.
//     - PARITY: the 8 data bits plus the parity bit must have an odd number of ones; latch the result -> STOP.
//     - STOP: bit=1 and parity ok -> push the byte, then IDLE.
//       - bit=0 -> frame_err=1, discard, IDLE.
//       - Parity bad -> parity_err=1, discard, IDLE. If parity is bad and the stop bit is also 0, both flags set.
//     - Timeout: in any state other than IDLE, TIMEOUT_CYCLES cycles with no fe -> frame_err=1, partial frame discarded, IDLE.
//       - The counter restarts on every fe.
//   Push timing: the byte enters the FIFO on the cycle after the stop-bit fe. It is visible to DATA reads on the next cycle.
//   FIFO behaviour, show-ahead:
//     - Push while full: drop the byte, set overrun=1.
//     - Push and pop in the same cycle while full: both happen, no overrun.
//     - Push and pop in the same cycle while empty: the push is kept, and the pop acts on the empty FIFO and is ignored.
//     - Pop while empty: no effect.
//     - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//   Sticky flags: if a set and a write-1-clear land in the same cycle, the set wins.
//   Reads of STATUS have no side effects. The host never drives PS/2 lines; this block is receive-only.
// STRUCTURE
//   Shared package ps2_pkg:
//     - Register offsets: REG_DATA=2'd0, REG_STATUS=2'd1.
//     - STATUS bit indices.
//     - FSM state encodings: IDLE, DATA, PARITY, STOP.
//   Sub-module ps2_rx_frame:
//     - Contents: synchronisers, filter, FSM, timeout.
//     - Outputs: rx_valid (1-cycle), rx_byte[7:0], parity_err_p, frame_err_p.
//   The FIFO and register file stay in ps2_keyboard.
// TESTING
//   1 Frame for 0x1C (data 00111000 LSB-first, parity 0, stop 1) at 10 kHz -> STATUS=0x01, DATA read=0x1C.
//       That read pops; the next STATUS read = 0x00.
//   2 Frame for 0x5A with the parity bit inverted -> STATUS=0x08, FIFO empty.
//       Write STATUS 0x08 -> STATUS=0x00.
//   3 Valid frame with stop bit=0 -> frame_err: STATUS=0x10. Separately, stop ps2_clk after 4 data bits
//       -> frame_err=1 within TIMEOUT_CYCLES+FILTER_LEN+3 cycles; the next full 0x29 frame is received correctly.
//   4 17 frames 0x01..0x11 with no reads, FIFO_DEPTH=16 -> STATUS=0x07.
//       16 reads return 0x01..0x10 in order; 0x11 is lost; the next STATUS read = 0x04.
//   5 Write STATUS 0x80, then one frame 0x76 -> irq rises once the byte is visible.
//       Reading DATA drops irq the next cycle; write 0x00 to STATUS keeps irq=0.
//   6 1-cycle glitches (< FILTER_LEN) on ps2_clk -> no bit shifted.
//       Assert rst_n=0 mid-frame -> all state clears; irq=0 while reset is held.
//       After release, a 0x12 frame is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared register map, status bits and receiver states for the PS/2 keyboard port
package ps2_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_NOT_EMPTY  = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERRUN    = 2;
  localparam int ST_PARITY_ERR = 3;
  localparam int ST_FRAME_ERR  = 4;
  localparam int ST_IRQ_EN     = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 pin synchronisers, clock filter and 11-bit frame receiver
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       parity_err_p,
  output logic       frame_err_p
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, data_sync;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt, clk_flt_q;
  logic          fe, bit_in, timeout;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          par_ok;
  rx_state_t     state, next_state;
  logic          start_c, shift_c, par_c, push_c, perr_c, ferr_c;

  // The filtered level only flips after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      flt_cnt   <= '0;
      clk_flt   <= 1'b1;
      clk_flt_q <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_flt_q <= clk_flt;
      if (clk_sync[1] == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_flt <= clk_sync[1];
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fe      = clk_flt_q & ~clk_flt;
  assign bit_in  = data_sync[1];
  assign timeout = (state != IDLE) && !fe && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign rx_byte = shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (timeout) begin
      next_state = IDLE;
    end else if (fe) begin
      case (state)
        IDLE:    if (!bit_in) next_state = DATA;
        DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    start_c = fe && (state == IDLE) && !bit_in;
    shift_c = fe && (state == DATA);
    par_c   = fe && (state == PARITY);
    push_c  = fe && (state == STOP) && bit_in && par_ok;
    perr_c  = fe && (state == STOP) && !par_ok;
    ferr_c  = (fe && (state == STOP) && !bit_in) || timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt      <= '0;
      shift_reg    <= '0;
      bit_cnt      <= '0;
      par_ok       <= 1'b0;
      rx_valid     <= 1'b0;
      parity_err_p <= 1'b0;
      frame_err_p  <= 1'b0;
    end else begin
      tmo_cnt      <= (state == IDLE || fe) ? '0 : tmo_cnt + 1'b1;
      rx_valid     <= push_c;
      parity_err_p <= perr_c;
      frame_err_p  <= ferr_c;
      if (start_c) bit_cnt <= '0;
      if (shift_c) begin
        shift_reg <= {bit_in, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (par_c) par_ok <= ^{shift_reg, bit_in};
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard receiver with scancode FIFO and CPU register interface
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_cs,
  input  logic       bus_ce,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       irq,
  input  logic       ps2_clk,
  input  logic       ps2_data
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic       rx_valid, parity_err_p, frame_err_p;
  logic [7:0] rx_byte;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic       empty, full, pop, do_pop, do_push, st_wr;
  logic       overrun, parity_err, frame_err, irq_en;
  logic       unused_bits;

  ps2_rx_frame #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .parity_err_p(parity_err_p),
    .frame_err_p (frame_err_p)
  );

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop     = ps2_cs && bus_ce && !we && (addr == REG_DATA);
  assign st_wr   = ps2_cs && bus_ce && we && (addr == REG_STATUS);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = rx_valid && (!full || do_pop);
  assign irq     = irq_en && !empty;
  assign unused_bits = ^{data_in[6:5], data_in[1:0]};

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      irq_en     <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      overrun    <= (rx_valid && full && !do_pop) || (overrun    && !(st_wr && data_in[ST_OVERRUN]));
      parity_err <= parity_err_p                  || (parity_err && !(st_wr && data_in[ST_PARITY_ERR]));
      frame_err  <= frame_err_p                   || (frame_err  && !(st_wr && data_in[ST_FRAME_ERR]));
      if (st_wr) irq_en <= data_in[ST_IRQ_EN];
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      REG_DATA:   data_out = empty ? 8'h00 : mem[rptr[AW-1:0]];
      REG_STATUS: begin
        data_out[ST_NOT_EMPTY]  = !empty;
        data_out[ST_FULL]       = full;
        data_out[ST_OVERRUN]    = overrun;
        data_out[ST_PARITY_ERR] = parity_err;
        data_out[ST_FRAME_ERR]  = frame_err;
        data_out[ST_IRQ_EN]     = irq_en;
      end
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - directed self-checking bench for ps2_keyboard
module tb_ps2_keyboard;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 400;
  localparam int DEPTH      = 16;
  localparam int HALF       = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_cs = 1'b0;
  logic       bus_ce = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       irq;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] rd;

  always #5 clk = ~clk;

  ps2_keyboard #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2_cs  (ps2_cs),
    .bus_ce  (bus_ce),
    .we      (we),
    .addr    (addr),
    .data_in (data_in),
    .data_out(data_out),
    .irq     (irq),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    ps2_cs = 1'b1; bus_ce = 1'b1; we = 1'b0; addr = a;
    #1 d = data_out;
    @(posedge clk);
    #1 ps2_cs = 1'b0; bus_ce = 1'b0;
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] v);
    @(negedge clk);
    ps2_cs = 1'b1; bus_ce = 1'b1; we = 1'b1; addr = a; data_in = v;
    @(posedge clk);
    #1 ps2_cs = 1'b0; bus_ce = 1'b0; we = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cpu_read(a, d);
    check(tag, d, exp);
  endtask

  // Sends the first nbits of a frame; glitch adds a 1-cycle low pulse during each high phase.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input logic glitch, input int nbits);
    logic [10:0] f;
    logic        p;
    p = ~(^b) ^ bad_par;
    f = {stop, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF / 2) @(negedge clk);
      if (glitch) begin
        ps2_clk = 1'b0;
        @(negedge clk);
        ps2_clk = 1'b1;
      end
      repeat (HALF / 2) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int waited;

    repeat (5) @(negedge clk);
    check("reset_irq", {7'd0, irq}, 8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    expect_reg("reset_status", 2'd1, 8'h00);
    expect_reg("reset_data_empty", 2'd0, 8'h00);

    // 1: good frame
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 11);
    expect_reg("t1_status", 2'd1, 8'h01);
    expect_reg("t1_reg2", 2'd2, 8'h00);
    expect_reg("t1_reg3_alias", 2'd3, 8'h00);
    expect_reg("t1_data", 2'd0, 8'h1C);
    expect_reg("t1_status_after_pop", 2'd1, 8'h00);

    // 2: parity error
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 11);
    expect_reg("t2_status", 2'd1, 8'h08);
    expect_reg("t2_data_empty", 2'd0, 8'h00);
    cpu_write(2'd1, 8'h08);
    expect_reg("t2_status_clr", 2'd1, 8'h00);

    // 3: stop bit error, then timeout, then recovery
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 11);
    expect_reg("t3_stop_err", 2'd1, 8'h10);
    cpu_write(2'd1, 8'h10);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 5);
    @(negedge clk);
    addr = 2'd1;
    #1 check("t3_before_timeout", data_out, 8'h00);
    waited = 0;
    while (!data_out[4] && waited < TIMEOUT + FILTER_LEN + 3) begin
      @(negedge clk);
      #1 waited++;
    end
    check("t3_timeout_ferr", data_out, 8'h10);
    cpu_write(2'd1, 8'h10);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 11);
    expect_reg("t3_recover_status", 2'd1, 8'h01);
    expect_reg("t3_recover_data", 2'd0, 8'h29);

    // 4: overrun
    for (int b = 1; b <= 17; b++) send_frame(8'(b), 1'b0, 1'b1, 1'b0, 11);
    expect_reg("t4_status_full", 2'd1, 8'h07);
    for (int b = 1; b <= 16; b++) begin
      cpu_read(2'd0, rd);
      check($sformatf("t4_data_%0d", b), rd, 8'(b));
    end
    expect_reg("t4_status_drained", 2'd1, 8'h04);
    cpu_write(2'd1, 8'h04);
    expect_reg("t4_status_clr", 2'd1, 8'h00);

    // 5: interrupt
    cpu_write(2'd1, 8'h80);
    #1 check("t5_irq_empty", {7'd0, irq}, 8'h00);
    send_frame(8'h76, 1'b0, 1'b1, 1'b0, 11);
    check("t5_irq_up", {7'd0, irq}, 8'h01);
    expect_reg("t5_status", 2'd1, 8'h81);
    cpu_read(2'd0, rd);
    check("t5_data", rd, 8'h76);
    check("t5_irq_down", {7'd0, irq}, 8'h00);
    cpu_write(2'd1, 8'h00);
    #1 check("t5_irq_disabled", {7'd0, irq}, 8'h00);
    expect_reg("t5_status_off", 2'd1, 8'h00);

    // 6: glitches, mid-frame reset
    send_frame(8'hB4, 1'b0, 1'b1, 1'b1, 11);
    expect_reg("t6_glitch_status", 2'd1, 8'h01);
    expect_reg("t6_glitch_data", 2'd0, 8'hB4);
    cpu_write(2'd1, 8'h80);
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 11);
    check("t6_irq_pre_reset", {7'd0, irq}, 8'h01);
    send_frame(8'h55, 1'b0, 1'b1, 1'b0, 4);
    @(negedge clk);
    rst_n = 1'b0;
    addr = 2'd1;
    #1 check("t6_irq_in_reset", {7'd0, irq}, 8'h00);
    check("t6_status_in_reset", data_out, 8'h00);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h12, 1'b0, 1'b1, 1'b0, 11);
    expect_reg("t6_post_status", 2'd1, 8'h01);
    expect_reg("t6_post_data", 2'd0, 8'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
